// File: rtl/aes_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_stream_pkg
// Description : Shared types and helpers for the byte-stream AES datapath.
//               Holds the ping-pong bank state encoding and the Rijndael
//               ShiftRows / InvShiftRows addressing functions.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_stream_pkg;

    // Lifecycle of one ping-pong bank
    typedef enum logic [1:0] {
        BANK_EMPTY    = 2'd0,
        BANK_FILLING  = 2'd1,
        BANK_FULL     = 2'd2,
        BANK_DRAINING = 2'd3
    } bank_state_t;

    // Column arithmetic width: enough for (NB-1) + NB with NB up to 8,
    // so the inverse path can add NB before the modulo without wrapping.
    localparam int unsigned c_col_w = $clog2(8) + 1;

    // Row rotation amount; the 8-column Rijndael variant skips offset 2.
    function automatic int unsigned row_offset(input int unsigned nb,
                                               input int unsigned r);
        if (nb == 8 && r >= 2) begin
            return r + 1;
        end else begin
            return r;
        end
    endfunction

    // Column-major index of the element that lands at output position j.
    function automatic int unsigned src_index(input int unsigned nb,
                                              input int unsigned j,
                                              input logic        inv);
        int unsigned          r;
        logic [c_col_w-1:0]   col;
        logic [c_col_w-1:0]   off;
        logic [c_col_w-1:0]   sum;
        logic [c_col_w-1:0]   src_col;
        r   = j % 4;
        col = c_col_w'(j / 4);
        off = c_col_w'(row_offset(nb, r));
        if (inv) begin
            sum = col - off + c_col_w'(nb);
        end else begin
            sum = col + off;
        end
        src_col = sum % c_col_w'(nb);
        return r + 4 * 32'(src_col);
    endfunction

endpackage
`default_nettype wire

// File: rtl/shift_rows_bank.sv
`default_nettype none
// ============================================================================
// Module      : shift_rows_bank
// Description : One half of the ShiftRows ping-pong buffer. An L-entry
//               register array written sequentially, read combinationally at
//               a permuted address, with its own state, mode bit and index
//               counter. The counter is the write index while filling and
//               the output index while draining.
// Ports       : clock, resetn      - clock, synchronous active-low reset
//               i_wr_en/data/inv   - element write (inv latched on element 0)
//               i_rd_en, i_rd_addr - output register load, read address
//               o_rd_data          - combinational read data
//               o_inv, o_count     - block mode and current element index
//               o_writable         - EMPTY or FILLING
//               o_readable         - FULL or DRAINING
// Revision    : 1.0 - initial release
// ============================================================================
module shift_rows_bank
    import aes_stream_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int L      = 16,
    parameter int AW     = $clog2(L)
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              i_wr_en,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_wr_inv,
    input  logic              i_rd_en,
    input  logic [AW-1:0]     i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_inv,
    output logic [AW-1:0]     o_count,
    output logic              o_writable,
    output logic              o_readable
);

    localparam logic [AW-1:0] c_last = AW'(L - 1);

    bank_state_t       r_state;
    bank_state_t       w_next_state;
    logic [DATA_W-1:0] r_mem [L];
    logic              r_inv;
    logic [AW-1:0]     r_count;
    logic              w_at_last;
    logic              w_step;

    assign w_at_last = (r_count == c_last);
    assign w_step    = (i_wr_en && o_writable) || (i_rd_en && o_readable);

    // State register
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state <= BANK_EMPTY;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            BANK_EMPTY:    if (i_wr_en)              w_next_state = BANK_FILLING;
            BANK_FILLING:  if (i_wr_en && w_at_last) w_next_state = BANK_FULL;
            BANK_FULL:     if (i_rd_en)              w_next_state = BANK_DRAINING;
            BANK_DRAINING: if (i_rd_en && w_at_last) w_next_state = BANK_EMPTY;
            default:                                 w_next_state = BANK_EMPTY;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        o_writable = (r_state == BANK_EMPTY) || (r_state == BANK_FILLING);
        o_readable = (r_state == BANK_FULL)  || (r_state == BANK_DRAINING);
    end

    // Shared index counter; L need not be a power of two, so wrap explicitly.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_count <= '0;
            r_inv   <= 1'b0;
        end else begin
            if (w_step) begin
                r_count <= w_at_last ? '0 : r_count + 1'b1;
            end
            if (i_wr_en && (r_state == BANK_EMPTY)) begin
                r_inv <= i_wr_inv;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (i_wr_en && o_writable) begin
            r_mem[r_count] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];
    assign o_inv     = r_inv;
    assign o_count   = r_count;

endmodule
`default_nettype wire

// File: rtl/shift_rows_stream.sv
`default_nettype none
// ============================================================================
// Module      : shift_rows_stream
// Description : Streaming Rijndael ShiftRows / InvShiftRows. Elements arrive
//               column-major, one per cycle, into a two-bank ping-pong buffer
//               and leave permuted through a single output register with
//               valid/ready backpressure. Direction is chosen per block.
// Ports       : clock, resetn                 - clock, sync active-low reset
//               in_data/in_valid/in_ready     - input element stream
//               in_inv                        - direction, sampled on elem 0
//               out_data/out_valid/out_ready  - permuted output stream
//               out_last                      - last element of a block
// Revision    : 1.0 - initial release
// ============================================================================
module shift_rows_stream
    import aes_stream_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int NB     = 4
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_inv,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last
);

    localparam int            L      = 4 * NB;
    localparam int            AW     = $clog2(L);
    localparam logic [AW-1:0] c_last = AW'(L - 1);

    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_valid;
    logic              r_out_last;

    logic              w_writable [2];
    logic              w_readable [2];
    logic              w_inv      [2];
    logic [AW-1:0]     w_count    [2];
    logic [DATA_W-1:0] w_rd_data  [2];
    logic              w_wr_en    [2];
    logic              w_rd_en    [2];

    logic              w_in_xfer;
    logic              w_load;
    logic              w_rd_last;
    logic [AW-1:0]     w_rd_count;
    logic [AW-1:0]     w_rd_addr;
    int unsigned       w_src;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        assign w_wr_en[b] = w_in_xfer && (r_wr_ptr == 1'(b));
        assign w_rd_en[b] = w_load    && (r_rd_ptr == 1'(b));

        shift_rows_bank #(
            .DATA_W (DATA_W),
            .L      (L),
            .AW     (AW)
        ) u_bank (
            .clock      (clock),
            .resetn     (resetn),
            .i_wr_en    (w_wr_en[b]),
            .i_wr_data  (in_data),
            .i_wr_inv   (in_inv),
            .i_rd_en    (w_rd_en[b]),
            .i_rd_addr  (w_rd_addr),
            .o_rd_data  (w_rd_data[b]),
            .o_inv      (w_inv[b]),
            .o_count    (w_count[b]),
            .o_writable (w_writable[b]),
            .o_readable (w_readable[b])
        );
    end

    assign in_ready   = resetn && w_writable[r_wr_ptr];
    assign w_in_xfer  = in_valid && in_ready;

    // The read bank's counter is the output position; translate it into the
    // stored position using the mode latched with that block's element 0.
    assign w_rd_count = w_count[r_rd_ptr];
    assign w_rd_last  = (w_rd_count == c_last);

    always_comb begin
        w_src = src_index(NB, 32'(w_rd_count), w_inv[r_rd_ptr]);
    end

    assign w_rd_addr  = AW'(w_src);

    // Refill the output register whenever it is empty or being consumed.
    assign w_load     = w_readable[r_rd_ptr] && (!r_out_valid || out_ready);

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
        end else begin
            if (w_in_xfer && (w_count[r_wr_ptr] == c_last)) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_load && w_rd_last) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else if (w_load) begin
            r_out_data  <= w_rd_data[r_rd_ptr];
            r_out_valid <= 1'b1;
            r_out_last  <= w_rd_last;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;

endmodule
`default_nettype wire

// File: tb/tb_shift_rows_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_rows_stream
// Description : Self-checking bench for shift_rows_stream with NB = 4 and
//               NB = 8 instances. Expected output comes from a row-rotation
//               model built on queues.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_rows_stream;

    logic       clock = 1'b0;
    logic       resetn;
    logic [7:0] in_data;
    logic       in_inv;
    logic       out_ready;

    logic       in_valid4, in_ready4, out_valid4, out_last4;
    logic [7:0] out_data4;
    logic       in_valid8, in_ready8, out_valid8, out_last8;
    logic [7:0] out_data8;

    always #5 clock = ~clock;

    shift_rows_stream #(.DATA_W(8), .NB(4)) dut4 (
        .clock(clock), .resetn(resetn), .in_data(in_data), .in_valid(in_valid4),
        .in_ready(in_ready4), .in_inv(in_inv), .out_data(out_data4),
        .out_valid(out_valid4), .out_ready(out_ready), .out_last(out_last4)
    );

    shift_rows_stream #(.DATA_W(8), .NB(8)) dut8 (
        .clock(clock), .resetn(resetn), .in_data(in_data), .in_valid(in_valid8),
        .in_ready(in_ready8), .in_inv(in_inv), .out_data(out_data8),
        .out_valid(out_valid8), .out_ready(out_ready), .out_last(out_last8)
    );

    typedef struct {logic [7:0] data; logic inv; bit first;} in_item_t;
    typedef struct {logic [7:0] data; bit last; bit first;} out_item_t;

    in_item_t    in_q[$];
    out_item_t   exp_q[$];
    int unsigned acc0_q[$];
    int unsigned lastacc_q[$];

    int          n_tests = 0;
    int          n_fail  = 0;
    int unsigned cyc     = 0;
    bit          sel8    = 1'b0;
    bit          chk_lat = 1'b0;
    bit          chk_rdy = 1'b0;
    int unsigned lat_l   = 16;
    int unsigned first_out_cyc, last_out_cyc;
    int          n_out   = 0;
    int          n_acc;
    logic        s_v, s_acc, s_rdy, s_ov, s_last;
    logic [7:0]  s_data;
    logic [7:0]  blk[32], fwd[32], ident[32];

    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: treat each row as a list and rotate it by its offset.
    function automatic void shift_model(input int nb, input bit inv,
                                        input logic [7:0] src[32], output logic [7:0] res[32]);
        logic [7:0] row[$];
        int         off;
        res = '{default: 8'h00};
        for (int r = 0; r < 4; r++) begin
            row = {};
            off = (nb == 8 && r >= 2) ? r + 1 : r;
            for (int c = 0; c < nb; c++) row.push_back(src[r + 4 * c]);
            repeat (off) begin
                if (inv) row.push_front(row.pop_back());
                else     row.push_back(row.pop_front());
            end
            for (int c = 0; c < nb; c++) res[r + 4 * c] = row[c];
        end
    endfunction

    task automatic push_raw(input int nb, input bit inv,
                            input logic [7:0] src[32], input logic [7:0] res[32]);
        for (int j = 0; j < 4 * nb; j++) begin
            in_q.push_back('{data: src[j], inv: inv, first: (j == 0)});
            exp_q.push_back('{data: res[j], last: (j == 4 * nb - 1), first: (j == 0)});
        end
    endtask

    task automatic push_block(input int nb, input bit inv, input bit rnd);
        logic [7:0] src[32], res[32];
        for (int j = 0; j < 32; j++) src[j] = rnd ? 8'($urandom) : 8'(j);
        shift_model(nb, inv, src, res);
        push_raw(nb, inv, src, res);
    endtask

    // One clock: drive at negedge, sample at negedge+1, commit after posedge.
    task automatic step(input bit send, input bit rdy);
        int unsigned cs;
        @(negedge clock);
        s_v = send && (in_q.size() > 0);
        out_ready = rdy;
        if (s_v) begin
            in_data = in_q[0].data;
            in_inv  = in_q[0].first ? in_q[0].inv : 1'($urandom);
        end else begin
            in_data = 8'($urandom);
            in_inv  = 1'($urandom);
        end
        in_valid4 = s_v && !sel8;
        in_valid8 = s_v && sel8;
        #1;
        cs     = cyc;
        s_rdy  = sel8 ? in_ready8  : in_ready4;
        s_ov   = sel8 ? out_valid8 : out_valid4;
        s_data = sel8 ? out_data8  : out_data4;
        s_last = sel8 ? out_last8  : out_last4;
        s_acc  = s_v && s_rdy;
        if (chk_rdy && s_v) check("in_ready_high", 32'(s_rdy), 32'd1);
        if (s_ov && !rdy) begin
            if (exp_q.size() > 0) check("held_data", 32'(s_data), 32'(exp_q[0].data));
            else                  check("spurious_valid", 32'(s_ov), 32'd0);
        end
        if (s_ov && rdy) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", 32'(s_ov), 32'd0);
            end else begin
                check("out_data", 32'(s_data), 32'(exp_q[0].data));
                check("out_last", 32'(s_last), 32'(exp_q[0].last));
                if (exp_q[0].first) begin
                    check("block_in_before_out", 32'(lastacc_q.size() > 0), 32'd1);
                    if (lastacc_q.size() > 0) begin
                        check("not_before_last_in", 32'(cs >= lastacc_q[0] + 1), 32'd1);
                        if (chk_lat) check("latency", cs - acc0_q[0], lat_l);
                        void'(acc0_q.pop_front());
                        void'(lastacc_q.pop_front());
                    end
                end
                if (n_out == 0) first_out_cyc = cs;
                last_out_cyc = cs;
                n_out++;
                void'(exp_q.pop_front());
            end
        end
        @(posedge clock);
        if (s_acc) begin
            if (in_q[0].first) acc0_q.push_back(cs + 1);
            if (in_q.size() == 1 || in_q[1].first) lastacc_q.push_back(cs + 1);
            void'(in_q.pop_front());
        end
    endtask

    task automatic run(input bit gaps, input int rdy_pct, input int budget);
        int n = 0;
        while ((in_q.size() > 0 || exp_q.size() > 0) && n < budget) begin
            step(gaps ? ($urandom_range(0, 3) != 0) : 1'b1, $urandom_range(1, 100) <= rdy_pct);
            n++;
        end
        check("run_complete", 32'(in_q.size() + exp_q.size()), 32'd0);
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        resetn = 1'b0; in_valid4 = 1'b0; in_valid8 = 1'b0; out_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        #1;
        check("rst_out_valid", 32'(out_valid4), 32'd0);
        check("rst_out_data",  32'(out_data4),  32'd0);
        check("rst_out_last",  32'(out_last4),  32'd0);
        check("rst_in_ready",  32'(in_ready4),  32'd0);
        check("rst_out_valid8", 32'(out_valid8), 32'd0);
        check("rst_in_ready8", 32'(in_ready8), 32'd0);
        in_q.delete(); exp_q.delete(); acc0_q.delete(); lastacc_q.delete();
        @(negedge clock);
        resetn = 1'b1;
        #1;
        check("in_ready_first_cycle",  32'(in_ready4), 32'd1);
        check("in_ready8_first_cycle", 32'(in_ready8), 32'd1);
    endtask

    initial begin
        resetn = 1'b0; in_valid4 = 1'b0; in_valid8 = 1'b0;
        in_data = 8'h00; in_inv = 1'b0; out_ready = 1'b0;
        pulse_reset();

        // NB=4 forward then inverse, sequential data, 16-cycle latency
        chk_lat = 1'b1; chk_rdy = 1'b1; lat_l = 16;
        push_block(4, 1'b0, 1'b0); run(1'b0, 100, 200);
        push_block(4, 1'b1, 1'b0); run(1'b0, 100, 200);

        // back-to-back forward + inverse with no bubble
        n_out = 0;
        push_block(4, 1'b0, 1'b0); push_block(4, 1'b1, 1'b0);
        run(1'b0, 100, 300);
        check("b2b_count", 32'(n_out), 32'd32);
        check("b2b_contiguous", last_out_cyc - first_out_cyc, 32'd31);

        // forward result pushed back through inverse returns identity
        for (int j = 0; j < 32; j++) begin blk[j] = 8'(j); ident[j] = 8'(j); end
        shift_model(4, 1'b0, blk, fwd);
        push_raw(4, 1'b1, fwd, ident); run(1'b0, 100, 200);

        // random data, random direction
        repeat (3) push_block(4, 1'($urandom), 1'b1);
        run(1'b0, 100, 400);

        // NB=8
        sel8 = 1'b1; lat_l = 32;
        push_block(8, 1'b0, 1'b0); push_block(8, 1'b1, 1'b1);
        run(1'b0, 100, 400);
        sel8 = 1'b0; lat_l = 16;

        // full backpressure: three blocks, only two fit
        chk_lat = 1'b0; chk_rdy = 1'b0;
        push_block(4, 1'b0, 1'b0); push_block(4, 1'b1, 1'b1); push_block(4, 1'b0, 1'b1);
        n_acc = 0;
        for (int k = 0; k < 60; k++) begin
            step(1'b1, 1'b0);
            if (s_acc) n_acc++;
            if (!s_rdy) break;
        end
        check("bp_accepted", 32'(n_acc), 32'd32);
        check("bp_in_ready_low", 32'(s_rdy), 32'd0);
        repeat (5) step(1'b1, 1'b0);
        check("bp_hold_valid", 32'(s_ov), 32'd1);
        check("bp_hold_00", 32'(s_data), 32'h00);
        run(1'b0, 100, 400);

        // gapped input with random backpressure
        repeat (4) push_block(4, 1'($urandom), 1'b1);
        run(1'b1, 50, 2000);

        // reset with one buffered block plus 7 elements of the next
        push_block(4, 1'b0, 1'b1); push_block(4, 1'b1, 1'b1);
        n_acc = 0;
        for (int k = 0; k < 60 && n_acc < 23; k++) begin
            step(1'b1, 1'b0);
            if (s_acc) n_acc++;
        end
        check("pre_reset_accepted", 32'(n_acc), 32'd23);
        pulse_reset();
        for (int k = 0; k < 20; k++) begin
            step(1'b0, 1'b1);
            check("no_output_after_reset", 32'(s_ov), 32'd0);
        end
        chk_lat = 1'b1; chk_rdy = 1'b1;
        push_block(4, 1'b0, 1'b0); run(1'b0, 100, 200);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/shift_rows_stream.md
# shift_rows_stream

Parametrised, streaming Rijndael ShiftRows / InvShiftRows unit. State elements arrive one per cycle in column-major order: element index j = r + 4c, with row r and column c. The block emits them permuted, with the direction selectable per block. It sits between the SubBytes/InvSubBytes and MixColumns/InvMixColumns byte streams of the encrypt/decrypt datapath. A ping-pong buffer allows back-to-back blocks at full throughput, and output backpressure is supported.

## Interface
- DATA_W, default 8: width of one state element.
- NB, default 4: number of state columns, one of 4, 6 or 8. Block length is L = 4·NB elements.
- clock  in  1: rising-edge clock.
- resetn  in  1: synchronous, active-low reset.
- in_data  in  DATA_W: input element.
- in_valid  in  1: in_data is valid.
- in_ready  out  1: the block can accept an element this cycle.
- in_inv  in  1: direction for the block, 0 = ShiftRows, 1 = InvShiftRows. Sampled only with element 0 of each block.
- out_data  out  DATA_W: permuted element.
- out_valid  out  1: out_data is valid.
- out_ready  in  1: downstream accepts out_data this cycle.
- out_last  out  1: out_data is element L−1 of the block.

## Operation
- Transfers:
  - An input transfer occurs when in_valid and in_ready are both high at a rising edge.
  - An output transfer occurs when out_valid and out_ready are both high at a rising edge.
- Row offsets off[r]:
  - NB = 4 or 6: off = {0,1,2,3}.
  - NB = 8: off = {0,1,3,4}.
- Permutation for output element j = r + 4c:
  - Forward: source column = (c + off[r]) mod NB.
  - Inverse: source column = (c − off[r] + NB) mod NB.
  - Source element index = r + 4·(source column).
  - The mod NB reduction is done on a $clog2(NB)+1 bit intermediate; no wrap errors at c = 0 or c = NB−1.
- Storage: two banks of L elements each. Each bank has a state, its own mode bit (inv) and an index counter.
- Bank states:
  - EMPTY → FILLING on an input transfer of element 0. The mode bit latches in_inv at that transfer.
  - FILLING → FULL on the input transfer of element L−1.
  - FULL → DRAINING when the output register loads element 0 of that bank.
  - DRAINING → EMPTY when the output register loads element L−1.
- Bank selection:
  - The write pointer toggles banks after each element L−1 written.
  - The read pointer toggles banks after each element L−1 read.
- in_ready is high when resetn = 1 and the write bank is EMPTY or FILLING.
- Output register:
  - Loads the next permuted element when the read bank is FULL or DRAINING and the register is empty or being transferred this cycle.
  - Holds out_data and out_last stable while out_valid = 1 and out_ready = 0.
- Simultaneous write to one bank and read from the other in the same cycle is normal operation.
- A bank never reads and writes in the same cycle.
- in_inv changes mid-block are ignored. Each block is emitted with the mode captured at its own element 0.

## Timing
- Reset values: out_data = 0, out_valid = 0, out_last = 0, in_ready = 0 while resetn = 0.
  - After reset, both banks are EMPTY, both pointers are 0, and in_ready = 1 on the first cycle with resetn = 1.
- Reset mid-operation: any partial or buffered block is discarded. Nothing from it is emitted after reset.
- Latency with out_ready held high: element k is accepted at edge e_k (e_0 … e_{L−1} consecutive), and output element k is valid after edge e_k + L. For L = 16, that is 16 cycles per element.
- Throughput: 1 element per cycle sustained, with no bubble between consecutive blocks, while in_valid = 1 and out_ready = 1.
- Gapped input: the first output of a block cannot appear before the edge after its element L−1 is accepted.
- Backpressure:
  - With out_ready = 0, at most 2L elements are buffered: one bank FULL plus the bank being drained.
  - Once both banks are occupied, in_ready = 0.
  - in_ready returns to 1 one cycle after the draining bank becomes EMPTY.

## Structure
- Package aes_stream_pkg holds:
  - the bank-state enum;
  - the function row_offset(nb, r);
  - the function src_index(nb, j, inv).
- One sub-module, shift_rows_bank: an L-entry register array with write port, combinational read port, state, mode bit and counter. It is instantiated twice.
- The top level holds the pointers, the permutation addressing and the output register.

## Test plan
- NB = 4, forward, input 00..0F:
  - Output is 00 05 0A 0F 04 09 0E 03 08 0D 02 07 0C 01 06 0B.
  - out_last is high only on 0B.
  - First out_valid is 16 edges after element 0.
- NB = 4, inverse, input 00..0F:
  - Output is 00 0D 0A 07 04 01 0E 0B 08 05 02 0F 0C 09 06 03.
- Back-to-back blocks, forward then inverse, with in_valid and out_ready always 1:
  - 32 contiguous outputs matching the two sequences above, in_ready never low.
  - Forward output fed back through an inverse block returns 00..0F.
- NB = 8, forward, input 00..1F:
  - Outputs 0..3 are 00 05 0E 13.
  - out_last is high on output 31.
- out_ready = 0 from the start for 3 blocks:
  - in_ready drops after 32 accepted elements.
  - out_data holds 00 stable.
  - Releasing out_ready yields the exact sequence, with no loss or duplication.
- resetn pulsed low after 7 elements of a block:
  - out_valid = 0, then the next full block is emitted correctly with 16-cycle latency.
